// File: rtl/pool_writeback_pkg.sv
// Shared definitions for the pooled CNN writeback stage.
//   state_t      : writeback FSM state encoding
//   POOL_BYPASS  : write every quantised pixel
//   POOL_MAX2    : 2x2 max pooling
//   FLUSH_CYCLES : pipeline depth drained after the last accepted pixel
package pool_writeback_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic POOL_BYPASS = 1'b0;
    localparam logic POOL_MAX2   = 1'b1;

    localparam int unsigned FLUSH_CYCLES = 2;

endpackage

// File: rtl/pool_writeback_param_relu_quant.sv
// relu_quant: combinational ReLU + right-shift quantisation + saturation
// for a single channel.
//   i_acc : signed accumulator result (ACCUM_DATA_WIDTH)
//   o_q   : quantised, non-negative result (DATA_WIDTH), clamped to
//           2^(DATA_WIDTH-1)-1
module relu_quant #(
    parameter int ACCUM_DATA_WIDTH = 32,
    parameter int DATA_WIDTH       = 16,
    parameter int SHIFT            = 8
) (
    input  logic [ACCUM_DATA_WIDTH-1:0] i_acc,
    output logic [DATA_WIDTH-1:0]       o_q
);

    localparam logic [ACCUM_DATA_WIDTH-1:0] W_MAX =
        ACCUM_DATA_WIDTH'((64'd1 << (DATA_WIDTH - 1)) - 64'd1);

    logic [ACCUM_DATA_WIDTH-1:0] w_shifted;

    // Negative inputs are zeroed first, so a logical shift of the remaining
    // non-negative values equals the arithmetic shift.
    always_comb begin
        w_shifted = i_acc >> SHIFT;
        if (i_acc[ACCUM_DATA_WIDTH-1]) begin
            o_q = '0;
        end else if (w_shifted > W_MAX) begin
            o_q = DATA_WIDTH'(W_MAX);
        end else begin
            o_q = DATA_WIDTH'(w_shifted);
        end
    end

endmodule

// File: rtl/pool_writeback_param.sv
// pool_writeback_param: post-accumulation output stage for a CNN layer.
// Quantises NUM_CH accumulator results per pixel (ReLU, shift, saturate),
// optionally 2x2 max-pools them through a half-row line buffer, and writes
// packed pixels into the output memory.
//   i_clk, i_rst_n       : clock, asynchronous active-low reset
//   i_start, i_pool_mode : begin a feature map; mode latched on accepted start
//   i_in_valid, i_in_data: one pixel of NUM_CH accumulator results
//   o_out_addr/data/wren : output memory write port
//   o_busy, o_done       : map in progress / one-cycle completion pulse
//   o_overrun            : sticky, in_valid seen outside RUN
module pool_writeback_param
    import pool_writeback_pkg::*;
#(
    parameter int NUM_CH           = 4,
    parameter int ACCUM_DATA_WIDTH = 32,
    parameter int DATA_WIDTH       = 16,
    parameter int SHIFT            = 8,
    parameter int FMAP_W           = 24,
    parameter int FMAP_H           = 24,
    parameter int POOL_ADDR_WIDTH  = 10
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_start,
    input  logic                               i_pool_mode,
    input  logic                               i_in_valid,
    input  logic [ACCUM_DATA_WIDTH*NUM_CH-1:0] i_in_data,
    output logic [POOL_ADDR_WIDTH-1:0]         o_out_addr,
    output logic [DATA_WIDTH*NUM_CH-1:0]       o_out_data,
    output logic                               o_out_wren,
    output logic                               o_busy,
    output logic                               o_done,
    output logic                               o_overrun
);

    localparam int COL_W    = (FMAP_W > 2) ? $clog2(FMAP_W) : 1;
    localparam int ROW_W    = (FMAP_H > 2) ? $clog2(FMAP_H) : 1;
    localparam int HALF_W   = FMAP_W / 2;
    localparam int LB_IDX_W = (HALF_W > 1) ? $clog2(HALF_W) : 1;
    localparam int PIX_W    = DATA_WIDTH * NUM_CH;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(FMAP_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(FMAP_H - 1);

    // FSM / control
    state_t                     r_state;
    logic                       r_mode;
    logic [COL_W-1:0]           r_col;
    logic [ROW_W-1:0]           r_row;
    logic                       r_flush_cnt;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_overrun;

    // Stage 1
    logic                       r_s1_valid;
    logic [PIX_W-1:0]           r_s1_data;
    logic [COL_W-1:0]           r_s1_col;
    logic [ROW_W-1:0]           r_s1_row;

    // Stage 2 / pooling state
    logic [PIX_W-1:0]           r_hold;
    logic [PIX_W-1:0]           r_linebuf [HALF_W];
    logic [POOL_ADDR_WIDTH-1:0] r_out_addr;
    logic [PIX_W-1:0]           r_out_data;
    logic                       r_out_wren;

    logic [PIX_W-1:0]           w_quant;
    logic                       w_accept;
    logic                       w_start_acc;
    logic                       w_last;
    logic [LB_IDX_W-1:0]        w_lb_idx;
    logic [PIX_W-1:0]           w_lb_rd;
    logic [PIX_W-1:0]           w_max_hc;
    logic [PIX_W-1:0]           w_max_lc;
    logic [POOL_ADDR_WIDTH-1:0] w_byp_addr;
    logic [POOL_ADDR_WIDTH-1:0] w_pool_addr;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_quant
        relu_quant #(
            .ACCUM_DATA_WIDTH (ACCUM_DATA_WIDTH),
            .DATA_WIDTH       (DATA_WIDTH),
            .SHIFT            (SHIFT)
        ) u_relu_quant (
            .i_acc (i_in_data[k*ACCUM_DATA_WIDTH +: ACCUM_DATA_WIDTH]),
            .o_q   (w_quant[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign w_accept    = i_in_valid && (r_state == S_RUN);
    assign w_start_acc = i_start && (r_state == S_IDLE);
    assign w_last      = w_accept && (r_col == LAST_COL) && (r_row == LAST_ROW);

    assign w_lb_idx = LB_IDX_W'(r_s1_col >> 1);
    assign w_lb_rd  = r_linebuf[w_lb_idx];

    assign w_byp_addr  = POOL_ADDR_WIDTH'(r_s1_row) * POOL_ADDR_WIDTH'(FMAP_W)
                       + POOL_ADDR_WIDTH'(r_s1_col);
    assign w_pool_addr = POOL_ADDR_WIDTH'(r_s1_row >> 1) * POOL_ADDR_WIDTH'(HALF_W)
                       + POOL_ADDR_WIDTH'(r_s1_col >> 1);

    // Per-channel unsigned maxima used by the pooling datapath.
    always_comb begin
        w_max_hc = '0;
        w_max_lc = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            w_max_hc[k*DATA_WIDTH +: DATA_WIDTH] =
                (r_hold[k*DATA_WIDTH +: DATA_WIDTH] > r_s1_data[k*DATA_WIDTH +: DATA_WIDTH])
                ? r_hold[k*DATA_WIDTH +: DATA_WIDTH] : r_s1_data[k*DATA_WIDTH +: DATA_WIDTH];
            w_max_lc[k*DATA_WIDTH +: DATA_WIDTH] =
                (w_lb_rd[k*DATA_WIDTH +: DATA_WIDTH] > r_s1_data[k*DATA_WIDTH +: DATA_WIDTH])
                ? w_lb_rd[k*DATA_WIDTH +: DATA_WIDTH] : r_s1_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Control FSM with registered busy/done/overrun.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_mode      <= POOL_BYPASS;
            r_col       <= '0;
            r_row       <= '0;
            r_flush_cnt <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // A stray in_valid wins over the clear, so in_valid coinciding
            // with the accepted start still leaves overrun set.
            if (i_in_valid && (r_state != S_RUN)) begin
                r_overrun <= 1'b1;
            end else if (w_start_acc) begin
                r_overrun <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_RUN;
                        r_mode  <= i_pool_mode;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (r_col == LAST_COL) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                        if (w_last) begin
                            r_state     <= S_FLUSH;
                            r_flush_cnt <= 1'b0;
                        end
                    end
                end
                S_FLUSH: begin
                    if (r_flush_cnt == 1'(FLUSH_CYCLES - 1)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Stage 1 (quantised data + raster position) and stage 2 (write port,
    // hold register).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_col   <= '0;
            r_s1_row   <= '0;
            r_hold     <= '0;
            r_out_addr <= '0;
            r_out_data <= '0;
            r_out_wren <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_data <= w_quant;
                r_s1_col  <= r_col;
                r_s1_row  <= r_row;
            end

            r_out_wren <= 1'b0;
            if (r_s1_valid) begin
                if (r_mode == POOL_BYPASS) begin
                    r_out_wren <= 1'b1;
                    r_out_addr <= w_byp_addr;
                    r_out_data <= r_s1_data;
                end else begin
                    case ({r_s1_row[0], r_s1_col[0]})
                        2'b00: r_hold <= r_s1_data;
                        2'b10: r_hold <= w_max_lc;
                        2'b11: begin
                            r_out_wren <= 1'b1;
                            r_out_addr <= w_pool_addr;
                            r_out_data <= w_max_hc;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Line buffer is never reset: every entry is rewritten on an even row
    // before the following odd row reads it.
    always_ff @(posedge i_clk) begin
        if (r_s1_valid && (r_mode == POOL_MAX2) && !r_s1_row[0] && r_s1_col[0]) begin
            r_linebuf[w_lb_idx] <= w_max_hc;
        end
    end

    assign o_out_addr = r_out_addr;
    assign o_out_data = r_out_data;
    assign o_out_wren = r_out_wren;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_pool_writeback_param.sv
// Self-checking bench for pool_writeback_param on a 4x4, 2-channel map.
module tb_pool_writeback_param;

    localparam int NCH = 2;
    localparam int AW  = 32;
    localparam int DW  = 16;
    localparam int PAW = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              pool_mode;
    logic              in_valid;
    logic [AW*NCH-1:0] in_data;
    logic [PAW-1:0]    out_addr;
    logic [DW*NCH-1:0] out_data;
    logic              out_wren;
    logic              busy;
    logic              done;
    logic              overrun;

    pool_writeback_param #(
        .NUM_CH           (NCH),
        .ACCUM_DATA_WIDTH (AW),
        .DATA_WIDTH       (DW),
        .SHIFT            (8),
        .FMAP_W           (4),
        .FMAP_H           (4),
        .POOL_ADDR_WIDTH  (PAW)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_pool_mode (pool_mode),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .o_out_addr  (out_addr),
        .o_out_data  (out_data),
        .o_out_wren  (out_wren),
        .o_busy      (busy),
        .o_done      (done),
        .o_overrun   (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] a0;
        logic [31:0] a1;
        logic [15:0] q0;
        logic [15:0] q1;
    } vec_t;

    wr_t  wq[$];
    wr_t  mon_w;
    int   done_cnt = 0;
    int   done_cyc = -1;
    logic busy_at_done = 1'b1;

    always @(negedge clk) begin
        if (out_wren) begin
            mon_w.cyc  = cyc;
            mon_w.addr = out_addr;
            mon_w.data = out_data;
            wq.push_back(mon_w);
        end
        if (done) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = busy;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    logic [31:0] p0 [16];
    logic [31:0] p1 [16];
    int          vcyc [16];
    int          e_n;
    logic [9:0]  e_addr [16];
    logic [31:0] e_data [16];
    int          e_pix [16];
    vec_t        tv [16];

    task automatic run_map(input logic mode, input int gap, input bit vws, input bit extra_start);
        wq.delete();
        @(posedge clk); #1;
        start = 1'b1;
        pool_mode = mode;
        if (vws) begin
            in_valid = 1'b1;
            in_data  = '1;
        end
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = {p1[i], p0[i]};
            vcyc[i]  = cyc;
            if (extra_start && i == 5) start = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            start    = 1'b0;
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic check_map(input string tag, input int done_before);
        chk({tag, "_nwr"}, 64'(wq.size()), 64'(e_n));
        for (int i = 0; i < e_n; i++) begin
            if (i < wq.size()) begin
                chk($sformatf("%s_addr%0d", tag, i), 64'(wq[i].addr), 64'(e_addr[i]));
                chk($sformatf("%s_data%0d", tag, i), 64'(wq[i].data), 64'(e_data[i]));
                chk($sformatf("%s_cyc%0d", tag, i), 64'(wq[i].cyc), 64'(vcyc[e_pix[i]] + 2));
            end
        end
        chk({tag, "_done_cnt"}, 64'(done_cnt - done_before), 64'd1);
        chk({tag, "_done_cyc"}, 64'(done_cyc), 64'(vcyc[15] + 3));
        chk({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
    endtask

    task automatic setup_bypass_ramp();
        for (int i = 0; i < 16; i++) begin
            p0[i]     = 32'(i * 256);
            p1[i]     = 32'hFFFF_FFFB;
            e_addr[i] = 10'(i);
            e_data[i] = {16'h0000, 16'(i)};
            e_pix[i]  = i;
        end
        e_n = 16;
    endtask

    task automatic setup_pool();
        for (int i = 0; i < 16; i++) begin
            p0[i] = 32'(i * 256);
            p1[i] = 32'((15 - i) * 256);
        end
        e_n = 4;
        e_addr[0] = 10'd0; e_data[0] = {16'd15, 16'd5};  e_pix[0] = 5;
        e_addr[1] = 10'd1; e_data[1] = {16'd13, 16'd7};  e_pix[1] = 7;
        e_addr[2] = 10'd2; e_data[2] = {16'd7,  16'd13}; e_pix[2] = 13;
        e_addr[3] = 10'd3; e_data[3] = {16'd5,  16'd15}; e_pix[3] = 15;
    endtask

    int db;

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        pool_mode = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;

        tv[0] = '{32'h7FFF_FFFF, 32'h0000_0180, 16'h7FFF, 16'h0001};
        tv[1] = '{32'h8000_0000, 32'h0000_0000, 16'h0000, 16'h0000};
        tv[2] = '{32'h007F_FF00, 32'h0080_0000, 16'h7FFF, 16'h7FFF};
        tv[3] = '{32'h0000_00FF, 32'h0000_0100, 16'h0000, 16'h0001};
        tv[4] = '{32'hFFFF_FFFF, 32'h0012_3456, 16'h0000, 16'h1234};
        tv[5] = '{32'h00FF_FFFF, 32'h0000_7FFF, 16'h7FFF, 16'h007F};
        tv[6] = '{32'h0000_0000, 32'hFFFF_FF00, 16'h0000, 16'h0000};
        tv[7] = '{32'h0001_2345, 32'h7FFF_0000, 16'h0123, 16'h7FFF};
        for (int i = 8; i < 16; i++) begin
            tv[i] = '{32'(i) << 12, ~32'(i), 16'(i) << 4, 16'h0000};
        end

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", 64'(out_addr), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_wren", 64'(out_wren), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        rst_n = 1'b1;

        // in_valid before any start
        wq.delete();
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = {32'd0, 32'h0000_1000};
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_start_overrun", 64'(overrun), 64'd1);
        chk("pre_start_nwr", 64'(wq.size()), 64'd0);
        chk("pre_start_busy", 64'(busy), 64'd0);

        // Bypass ramp, with a second start mid-map that must be ignored
        setup_bypass_ramp();
        db = done_cnt;
        run_map(1'b0, 0, 1'b0, 1'b1);
        check_map("byp_ramp", db);
        chk("byp_ramp_overrun_cleared", 64'(overrun), 64'd0);

        // Bypass table: saturation, truncation, negatives
        for (int i = 0; i < 16; i++) begin
            p0[i]     = tv[i].a0;
            p1[i]     = tv[i].a1;
            e_addr[i] = 10'(i);
            e_data[i] = {tv[i].q1, tv[i].q0};
            e_pix[i]  = i;
        end
        e_n = 16;
        db = done_cnt;
        run_map(1'b0, 0, 1'b0, 1'b0);
        check_map("byp_tbl", db);

        // in_valid while idle after done
        @(posedge clk); #1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("idle_overrun", 64'(overrun), 64'd1);

        // Pool, back-to-back pixels; start clears overrun
        setup_pool();
        db = done_cnt;
        run_map(1'b1, 0, 1'b0, 1'b0);
        check_map("pool", db);
        chk("pool_overrun_cleared", 64'(overrun), 64'd0);

        // Pool, in_valid every third cycle; in_valid with start is dropped
        setup_pool();
        db = done_cnt;
        run_map(1'b1, 2, 1'b1, 1'b0);
        check_map("pool_gap", db);
        chk("vws_overrun", 64'(overrun), 64'd1);

        // Reset mid-map in pool mode, landing on a write cycle
        setup_pool();
        wq.delete();
        @(posedge clk); #1;
        start     = 1'b1;
        pool_mode = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = {p1[i], p0[i]};
            vcyc[i]  = cyc;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("midrst_pre_wren", 64'(out_wren), 64'd1);
        chk("midrst_pre_busy", 64'(busy), 64'd1);
        db = done_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_addr", 64'(out_addr), 64'd0);
        chk("midrst_data", 64'(out_data), 64'd0);
        chk("midrst_wren", 64'(out_wren), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_overrun", 64'(overrun), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_done", 64'(done_cnt - db), 64'd0);

        // Full bypass map after the abandoned one
        setup_bypass_ramp();
        db = done_cnt;
        run_map(1'b0, 0, 1'b0, 1'b0);
        check_map("post_rst", db);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard bound on simulation time.
    initial begin
        #200000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1);
    end

endmodule
